mux_n_pipe: RTL and testbench

MUX_N_PIPE -- requirements
Module: mux_n_pipe

---
 rtl/mux_n_pipe_if.sv | 35 +++
 rtl/mux_n_pipe.sv | 101 ++++++++++
 tb/tb_mux_n_pipe.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_pipe_if.sv
// Handshake bundle for mux_n_pipe: N words of W bits plus select with in_valid/in_ready,
// selected word y with out_valid/out_ready; sel_err exists only under MUX_N_PIPE_SEL_ERR_EN.
interface mux_n_pipe_if #(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int S = $clog2(N);

    logic [N*W-1:0] a;
    logic [S-1:0]   s;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   y;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    logic           sel_err;
`endif

    modport master (
        output a, s, in_valid, out_ready,
`ifdef MUX_N_PIPE_SEL_ERR_EN
        input  sel_err,
`endif
        input  in_ready, y, out_valid
    );

    modport slave (
        input  a, s, in_valid, out_ready,
`ifdef MUX_N_PIPE_SEL_ERR_EN
        output sel_err,
`endif
        output in_ready, y, out_valid
    );
endinterface

// File: rtl/mux_n_pipe.sv
// Pipelined N:1 word mux: S=$clog2(N) registered 2:1 layers, valid/ready stalled as one unit.
// Ports: clk, rst_n (async low), bus (mux_n_pipe_if.slave); MUX_N_PIPE_SEL_ERR_EN adds sel_err.
module mux_n_pipe #(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_n_pipe_if.slave bus
);
    localparam int S  = $clog2(N);
    localparam int N2 = 1 << S;

    logic            adv;
    logic [N2*W-1:0] pad;

    // Whole pipe moves together; any empty output slot lets it shift.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        pad          = '0;
        pad[N*W-1:0] = bus.a;
    end

    for (genvar k = 1; k <= S; k++) begin : g_lyr
        localparam int WI = (N2 >> (k - 1)) * W;
        localparam int WO = (N2 >> k) * W;

        logic [WI-1:0] d_in;
        logic [S-k:0]  s_in;
        logic          v_in;
        logic [WO-1:0] d_nx;
        logic [WO-1:0] d_q;
        logic          v_q;
`ifdef MUX_N_PIPE_SEL_ERR_EN
        logic          e_in;
        logic          e_q;
`endif

        if (k == 1) begin : g_src
            assign d_in = pad;
            assign s_in = bus.s;
            assign v_in = bus.in_valid;
`ifdef MUX_N_PIPE_SEL_ERR_EN
            assign e_in = (int'(bus.s) >= N);
`endif
        end else begin : g_src
            assign d_in = g_lyr[k-1].d_q;
            assign s_in = g_lyr[k-1].g_sq.s_q;
            assign v_in = g_lyr[k-1].v_q;
`ifdef MUX_N_PIPE_SEL_ERR_EN
            assign e_in = g_lyr[k-1].e_q;
`endif
        end

        // s_in[0] is this layer's select; it picks within each adjacent pair.
        always_comb begin
            d_nx = '0;
            for (int j = 0; j < WO / W; j++) begin
                d_nx[j*W +: W] = s_in[0] ? d_in[(2*j+1)*W +: W]
                                         : d_in[2*j*W +: W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                d_q <= '0;
                v_q <= 1'b0;
`ifdef MUX_N_PIPE_SEL_ERR_EN
                e_q <= 1'b0;
`endif
            end else if (adv) begin
                d_q <= d_nx;
                v_q <= v_in;
`ifdef MUX_N_PIPE_SEL_ERR_EN
                e_q <= e_in;
`endif
            end
        end

        // Remaining select bits travel with the data; the last layer needs none.
        if (k < S) begin : g_sq
            logic [S-k-1:0] s_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_q <= '0;
                end else if (adv) begin
                    s_q <= s_in[S-k:1];
                end
            end
        end
    end

    assign bus.y         = g_lyr[S].d_q;
    assign bus.out_valid = g_lyr[S].v_q;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    assign bus.sel_err   = g_lyr[S].e_q && g_lyr[S].v_q;
`endif
endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: three instances (N=8/W=4, N=5/W=8, N=2/W=16), directed and
// randomized traffic checked against a queue-based word-select model.
module tb_mux_n_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [16:0] q [3][$];
    logic        hold [3];
    logic [63:0] held [3];

    always #5 clk = ~clk;

    mux_n_pipe_if #(.N(8), .W(4))  b8 ();
    mux_n_pipe_if #(.N(5), .W(8))  b5 ();
    mux_n_pipe_if #(.N(2), .W(16)) b2 ();

    mux_n_pipe #(.N(8), .W(4))  u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    mux_n_pipe #(.N(5), .W(8))  u5 (.clk(clk), .rst_n(rst_n), .bus(b5));
    mux_n_pipe #(.N(2), .W(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    function automatic int nk(int k);
        return (k == 0) ? 8 : ((k == 1) ? 5 : 2);
    endfunction

    function automatic int wk(int k);
        return (k == 0) ? 4 : ((k == 1) ? 8 : 16);
    endfunction

    function automatic logic [15:0] pick(logic [63:0] a, int s, int n, int w);
        logic [63:0] m;
        if (s >= n) return 16'd0;
        m = (64'd1 << w) - 64'd1;
        return 16'((a >> (s * w)) & m);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    endtask

    task automatic rand_in(int k);
        case (k)
            0: begin b8.a = $urandom(); b8.s = 3'($urandom()); end
            1: begin b5.a = {8'($urandom()), $urandom()}; b5.s = 3'($urandom()); end
            default: begin b2.a = $urandom(); b2.s = 1'($urandom()); end
        endcase
    endtask

    // Observe one cycle just before the edge, update the model, end at the next negedge.
    task automatic tick();
        logic        ov [3];
        logic        rd [3];
        logic        iv [3];
        logic        ir [3];
        logic        er [3];
        logic [15:0] yv [3];
        logic [63:0] av [3];
        int          sv [3];
        logic [16:0] e;
        #1;
        ov[0] = b8.out_valid; rd[0] = b8.out_ready; iv[0] = b8.in_valid;
        ir[0] = b8.in_ready;  yv[0] = 16'(b8.y);    av[0] = 64'(b8.a);
        sv[0] = int'(b8.s);
        ov[1] = b5.out_valid; rd[1] = b5.out_ready; iv[1] = b5.in_valid;
        ir[1] = b5.in_ready;  yv[1] = 16'(b5.y);    av[1] = 64'(b5.a);
        sv[1] = int'(b5.s);
        ov[2] = b2.out_valid; rd[2] = b2.out_ready; iv[2] = b2.in_valid;
        ir[2] = b2.in_ready;  yv[2] = 16'(b2.y);    av[2] = 64'(b2.a);
        sv[2] = int'(b2.s);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        er[0] = b8.sel_err; er[1] = b5.sel_err; er[2] = b2.sel_err;
`else
        er[0] = 1'b0; er[1] = 1'b0; er[2] = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            if (hold[k])
                chk($sformatf("hold%0d", k), {46'd0, ov[k], er[k], yv[k]}, held[k]);
            hold[k] = ov[k] && !rd[k];
            held[k] = {46'd0, ov[k], er[k], yv[k]};
            chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(!ov[k] || rd[k]));
            if (ov[k] && rd[k]) begin
                chk($sformatf("pending%0d", k), 64'(q[k].size() != 0), 64'd1);
                if (q[k].size() != 0) begin
                    e = q[k].pop_front();
                    chk($sformatf("y%0d", k), 64'(yv[k]), 64'(e[15:0]));
`ifdef MUX_N_PIPE_SEL_ERR_EN
                    chk($sformatf("sel_err%0d", k), 64'(er[k]), 64'(e[16]));
`endif
                end
            end
            if (iv[k] && ir[k])
                q[k].push_back({sv[k] >= nk(k), pick(av[k], sv[k], nk(k), wk(k))});
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) hold[k] = 1'b0;
        rst_n = 1'b0;
        b8.a = '0; b8.s = '0;
        b5.a = '0; b5.s = '0;
        b2.a = '0; b2.s = '0;
        idle();
        repeat (2) @(negedge clk);

        chk("rst_ov8", 64'(b8.out_valid), 64'd0);
        chk("rst_y8",  64'(b8.y),         64'd0);
        chk("rst_ir8", 64'(b8.in_ready),  64'd1);
        chk("rst_ov5", 64'(b5.out_valid), 64'd0);
        chk("rst_y5",  64'(b5.y),         64'd0);
        chk("rst_ov2", 64'(b2.out_valid), 64'd0);
        chk("rst_y2",  64'(b2.y),         64'd0);
        chk("rst_ir2", 64'(b2.in_ready),  64'd1);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("rst_err5", 64'(b5.sel_err), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single words: latency and out-of-range select.
        b8.a = 32'h7654_3210; b8.s = 3'd5; b8.in_valid = 1'b1;
        b5.a = 40'hA4_A3_A2_A1_A0; b5.s = 3'd6; b5.in_valid = 1'b1;
        b2.a = 32'hBEEF_1234; b2.s = 1'b1; b2.in_valid = 1'b1;
        tick();
        idle();
        chk("lat2_ov", 64'(b2.out_valid), 64'd1);
        chk("lat2_y",  64'(b2.y),         64'hBEEF);
        chk("lat8_ov1", 64'(b8.out_valid), 64'd0);
        tick();
        chk("lat8_ov2", 64'(b8.out_valid), 64'd0);
        chk("lat5_ov2", 64'(b5.out_valid), 64'd0);
        chk("lat2_ov2", 64'(b2.out_valid), 64'd0);
        tick();
        chk("lat8_ov3", 64'(b8.out_valid), 64'd1);
        chk("lat8_y",   64'(b8.y),         64'h5);
        chk("lat5_ov3", 64'(b5.out_valid), 64'd1);
        chk("oor5_y",   64'(b5.y),         64'h0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("oor5_err", 64'(b5.sel_err), 64'd1);
`endif

        b8.s = 3'd7; b8.in_valid = 1'b1;
        b5.s = 3'd4; b5.in_valid = 1'b1;
        b2.s = 1'b0; b2.in_valid = 1'b1;
        tick();
        idle();
        chk("sel2_0", 64'(b2.y), 64'h1234);
        tick();
        tick();
        chk("sel8_7", 64'(b8.y), 64'h7);
        chk("sel5_4", 64'(b5.y), 64'hA4);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("last5_err", 64'(b5.sel_err), 64'd0);
`endif
        tick();

        // Back-to-back stream s=0..7 on the N=8 instance.
        for (int i = 0; i < 10; i++) begin
            b8.in_valid = (i < 8);
            b8.s = 3'(i);
            b8.a = $urandom();
            tick();
            chk("stream_ir", 64'(b8.in_ready), 64'd1);
            if (i >= 2) chk("stream_ov", 64'(b8.out_valid), 64'd1);
        end
        b8.in_valid = 1'b0;
        tick();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 3; k++) rand_in(k);
            b8.in_valid = ($urandom_range(3) != 0);
            b5.in_valid = ($urandom_range(3) != 0);
            b2.in_valid = ($urandom_range(3) != 0);
            b8.out_ready = ($urandom_range(2) != 0);
            b5.out_ready = ($urandom_range(2) != 0);
            b2.out_ready = ($urandom_range(2) != 0);
            tick();
        end
        idle();
        repeat (4) tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("drain%0d", k), 64'(q[k].size()), 64'd0);

        // Fill N=8 pipe against a stalled consumer, then drain.
        b8.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rand_in(0);
            b8.in_valid = 1'b1;
            tick();
            if (i >= 2) begin
                chk("stall_ir", 64'(b8.in_ready),  64'd0);
                chk("stall_ov", 64'(b8.out_valid), 64'd1);
                chk("stall_q",  64'(q[0].size()),  64'd3);
            end
        end
        b8.in_valid = 1'b0;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_ov", 64'(b8.out_valid), 64'd1);
            tick();
        end
        chk("drain_end", 64'(b8.out_valid), 64'd0);
        chk("drain_q",   64'(q[0].size()),  64'd0);

        // Reset with words in flight on every instance.
        for (int k = 0; k < 3; k++) rand_in(k);
        b8.s = 3'd3; b5.s = 3'd7; b2.s = 1'b1;
        b8.in_valid = 1'b1; b5.in_valid = 1'b1; b2.in_valid = 1'b1;
        tick();
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ov8", 64'(b8.out_valid), 64'd0);
        chk("mid_y8",  64'(b8.y),         64'd0);
        chk("mid_ov2", 64'(b2.out_valid), 64'd0);
        chk("mid_y2",  64'(b2.y),         64'd0);
        chk("mid_ov5", 64'(b5.out_valid), 64'd0);
`ifdef MUX_N_PIPE_SEL_ERR_EN
        chk("mid_err5", 64'(b5.sel_err), 64'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            hold[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stale8", 64'(b8.out_valid), 64'd0);
            chk("stale5", 64'(b5.out_valid), 64'd0);
            chk("stale2", 64'(b2.out_valid), 64'd0);
        end

        // One clean transfer after reset release.
        rand_in(0);
        b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        tick();
        tick();
        chk("post_ov8", 64'(b8.out_valid), 64'd1);
        repeat (2) tick();
        for (int k = 0; k < 3; k++)
            chk($sformatf("final_q%0d", k), 64'(q[k].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
